// File: rtl/simon_pkg.sv
// Shared definitions for the button conditioning block: per-channel debounce
// state encodings and default timing parameters.
package simon_pkg;

  typedef enum logic [1:0] {
    S_REL    = 2'd0,
    S_PEND_P = 2'd1,
    S_HELD   = 2'd2,
    S_PEND_R = 2'd3
  } chan_state_t;

  localparam int DEBOUNCE_MS_DEFAULT = 10;
  localparam int LONG_MS_DEFAULT     = 1000;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bus between the raw pins / game controller and the debounce block.
// slave modport is the debounce block, master is its environment.
interface btn_debounce_if #(
  parameter int NUM_BTN = 4
);
  logic [15:0]        ticks_per_milli;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_clean;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               btn_single;
  logic [1:0]         btn_index;
  logic [NUM_BTN-1:0] long_press;

  modport slave (
    input  ticks_per_milli, btn_raw,
    output btn_clean, btn_press, btn_release, btn_single, btn_index, long_press
  );

  modport master (
    output ticks_per_milli, btn_raw,
    input  btn_clean, btn_press, btn_release, btn_single, btn_index, long_press
  );
endinterface

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, four-state debounce FSM with an
// 8-bit ms count, registered press/release strobes and, when BTN_LONG_PRESS_EN
// is defined, a saturating hold counter producing a long-press strobe.
module debounce_chan
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  parameter int LONG_MS     = LONG_MS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_ms_tick,
  output logic o_clean,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255) begin : g_bad_debounce
    $error("debounce_chan: DEBOUNCE_MS out of range 1..255");
  end
  if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long
    $error("debounce_chan: LONG_MS out of range 1..65535");
  end

  localparam logic [7:0] LP_LAST = 8'(DEBOUNCE_MS - 1);

  logic        r_s1, r_s2;
  chan_state_t r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_press, w_press_nxt;
  logic        r_release, w_release_nxt;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // FSM state, ms count and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_REL;
      r_cnt     <= 8'd0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next-state: a new level must survive DEBOUNCE_MS ms ticks to be accepted
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      S_REL: begin
        if (r_s2) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_PEND_P;
        end
      end
      S_PEND_P: begin
        if (!r_s2) begin
          w_state_nxt = S_REL;
        end else if (i_ms_tick) begin
          if (r_cnt == LP_LAST) begin
            w_state_nxt = S_HELD;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      S_HELD: begin
        if (!r_s2) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_PEND_R;
        end
      end
      S_PEND_R: begin
        if (r_s2) begin
          w_state_nxt = S_HELD;
        end else if (i_ms_tick) begin
          if (r_cnt == LP_LAST) begin
            w_state_nxt   = S_REL;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = S_REL;
    endcase
  end

  assign o_clean   = (r_state == S_HELD) || (r_state == S_PEND_R);
  assign o_press   = r_press;
  assign o_release = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [15:0] LP_LONG = 16'(LONG_MS);

  logic [15:0] r_hold, w_hold_nxt;
  logic        r_long, w_long_nxt;

  // Hold counter: restarts on a fresh press, pauses while release is pending
  always_comb begin
    w_hold_nxt = r_hold;
    w_long_nxt = 1'b0;
    if (r_state == S_PEND_P && w_state_nxt == S_HELD) begin
      w_hold_nxt = 16'd0;
    end else if (r_state == S_HELD && i_ms_tick && r_hold < LP_LONG) begin
      w_hold_nxt = r_hold + 16'd1;
      w_long_nxt = (r_hold + 16'd1 == LP_LONG);
    end
  end

  // Hold counter and long-press strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 16'd0;
      r_long <= 1'b0;
    end else begin
      r_hold <= w_hold_nxt;
      r_long <= w_long_nxt;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Button input conditioning: shared millisecond time base, NUM_BTN debounce
// channels and a one-hot-to-index decode of the clean levels.
// Optional long-press strobes are enabled by defining BTN_LONG_PRESS_EN.
module btn_debounce
  import simon_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
  parameter int LONG_MS     = LONG_MS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

  logic [15:0]        r_ms_cnt;
  logic [15:0]        w_ms_last;
  logic               w_ms_tick;
  logic [NUM_BTN-1:0] w_clean;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic [NUM_BTN-1:0] w_long;
  logic [7:0]         w_pop;
  logic [1:0]         w_idx;
  logic               w_single;

  // A limit of 0 behaves like 1 so the tick then fires every cycle
  assign w_ms_last = (bus.ticks_per_milli == 16'd0) ? 16'd0
                                                    : bus.ticks_per_milli - 16'd1;
  assign w_ms_tick = (r_ms_cnt == w_ms_last);

  // Ms counter; also wraps silently if the limit drops below the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms_cnt <= 16'd0;
    end else if (r_ms_cnt >= w_ms_last) begin
      r_ms_cnt <= 16'd0;
    end else begin
      r_ms_cnt <= r_ms_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (bus.btn_raw[g]),
      .i_ms_tick (w_ms_tick),
      .o_clean   (w_clean[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_long    (w_long[g])
    );
  end

  // Popcount and set-bit position of the clean levels
  always_comb begin
    w_pop = 8'd0;
    w_idx = 2'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (w_clean[i]) begin
        w_pop = w_pop + 8'd1;
        w_idx = 2'(i);
      end
    end
  end

  assign w_single        = (w_pop == 8'd1);
  assign bus.btn_clean   = w_clean;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.long_press  = w_long;
  assign bus.btn_single  = w_single;
  assign bus.btn_index   = w_single ? w_idx : 2'd0;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DEBOUNCE_MS=5, LONG_MS=20).
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_btn_debounce;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  btn_debounce_if #(.NUM_BTN(4)) bif ();

  btn_debounce #(
    .NUM_BTN     (4),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input int max, output int n, output logic [3:0] val);
    n   = 0;
    val = 4'd0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (bif.btn_press != 4'd0) begin
        n   = i;
        val = bif.btn_press;
        break;
      end
    end
  endtask

  task automatic wait_clean_zero(input string tag);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bif.btn_clean == 4'd0) break;
    end
    chk(tag, {28'd0, bif.btn_clean}, 32'd0);
  endtask

  initial begin
    int         n;
    logic [3:0] v;
    int         bad;
    int         rel_cnt;
    logic [3:0] rel_val;
    int         long_first;
    int         long_cnt;

    // Reset with all pins pressed
    rst_n = 1'b0;
    bif.ticks_per_milli = 16'd4;
    bif.btn_raw = 4'b1111;
    step(3);
    chk("rst_clean",   {28'd0, bif.btn_clean},   32'd0);
    chk("rst_press",   {28'd0, bif.btn_press},   32'd0);
    chk("rst_release", {28'd0, bif.btn_release}, 32'd0);
    chk("rst_single",  {31'd0, bif.btn_single},  32'd0);
    chk("rst_index",   {30'd0, bif.btn_index},   32'd0);
    chk("rst_long",    {28'd0, bif.long_press},  32'd0);
    rst_n = 1'b1;
    wait_press(40, n, v);
    chk("rst_rel_latency", n, 20);
    chk("rst_rel_press", {28'd0, v}, 32'hF);
    chk("rst_rel_clean", {28'd0, bif.btn_clean}, 32'hF);
    chk("all4_single", {31'd0, bif.btn_single}, 32'd0);
    step(1);
    chk("press_one_cycle", {28'd0, bif.btn_press}, 32'd0);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("rst_all_released");

    // Bounce on channel 2
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bif.btn_raw = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bif.btn_press != 4'd0 || bif.btn_release != 4'd0) bad++;
      end
    end
    chk("bounce_no_strobe", bad, 0);
    bif.btn_raw = 4'b0100;
    wait_press(40, n, v);
    chk("bounce_latency_window", {31'd0, (n >= 20 && n <= 23)}, 32'd1);
    chk("bounce_press", {28'd0, v}, 32'h4);
    chk("bounce_single", {31'd0, bif.btn_single}, 32'd1);
    chk("bounce_index",  {30'd0, bif.btn_index},  32'd2);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("bounce_released");

    // Release glitch on channel 1
    bif.btn_raw = 4'b0010;
    wait_press(40, n, v);
    chk("glitch_press", {28'd0, v}, 32'h2);
    chk("glitch_index", {30'd0, bif.btn_index}, 32'd1);
    rel_cnt = 0;
    bad     = 0;
    bif.btn_raw = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bif.btn_release != 4'd0) rel_cnt++;
      if (!bif.btn_clean[1]) bad++;
    end
    bif.btn_raw = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bif.btn_release != 4'd0) rel_cnt++;
      if (!bif.btn_clean[1]) bad++;
    end
    chk("short_drop_no_release", rel_cnt, 0);
    chk("short_drop_clean_held", bad, 0);
    rel_cnt = 0;
    rel_val = 4'd0;
    bif.btn_raw = 4'b0000;
    for (int c = 0; c < 54; c++) begin
      if (c == 24) bif.btn_raw = 4'b0010;
      @(negedge clk);
      if (bif.btn_release != 4'd0) begin
        rel_cnt++;
        rel_val = bif.btn_release;
      end
    end
    chk("long_drop_release_count", rel_cnt, 1);
    chk("long_drop_release_val", {28'd0, rel_val}, 32'h2);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("glitch_released");

    // Multi-press
    bif.btn_raw = 4'b0001;
    wait_press(40, n, v);
    chk("multi_first_press", {28'd0, v}, 32'h1);
    chk("multi_first_single", {31'd0, bif.btn_single}, 32'd1);
    chk("multi_first_index", {30'd0, bif.btn_index}, 32'd0);
    bif.btn_raw = 4'b1001;
    wait_press(40, n, v);
    chk("multi_second_press", {28'd0, v}, 32'h8);
    chk("multi_clean", {28'd0, bif.btn_clean}, 32'h9);
    chk("multi_single", {31'd0, bif.btn_single}, 32'd0);
    chk("multi_index", {30'd0, bif.btn_index}, 32'd0);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("multi_released");

    // Async reset while channel 0 is pending
    bif.btn_raw = 4'b0001;
    step(10);
    chk("pend_not_yet", {28'd0, bif.btn_clean}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midreset_press", {28'd0, bif.btn_press}, 32'd0);
    chk("midreset_clean", {28'd0, bif.btn_clean}, 32'd0);
    step(1);
    rst_n = 1'b1;
    wait_press(40, n, v);
    chk("after_reset_restart_latency", n, 20);
    chk("after_reset_press", {28'd0, v}, 32'h1);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("reset_test_released");

    // Long hold on channel 3 with a 1-cycle millisecond
    bif.ticks_per_milli = 16'd1;
    step(2);
    bif.btn_raw = 4'b1000;
    wait_press(40, n, v);
    chk("long_hold_press", {28'd0, v}, 32'h8);
    chk("long_hold_index", {30'd0, bif.btn_index}, 32'd3);
    long_first = 0;
    long_cnt   = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bif.long_press != 4'd0) begin
        if (long_cnt == 0) long_first = i;
        long_cnt++;
        chk("long_press_val", {28'd0, bif.long_press}, 32'h8);
      end
    end
`ifdef BTN_LONG_PRESS_EN
    chk("long_press_count", long_cnt, 1);
    chk("long_press_delay", long_first, 20);
`else
    chk("long_press_absent", long_cnt, 0);
`endif
    chk("long_hold_still_clean", {28'd0, bif.btn_clean}, 32'h8);
    bif.btn_raw = 4'b0000;
    wait_clean_zero("long_released");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
